gestor_jugada: RTL and testbench

GESTOR_JUGADA -- requirements
Module: gestor_jugada

---
 rtl/gestor_jugada.sv | 184 ++++++++++++++++++
 tb/tb_gestor_jugada.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/gestor_jugada.sv
// Turn manager for a column-drop board game (Connect-Four style).
// The player moves a one-hot cursor across the non-full columns and drops a
// piece. The piece settles one row per cycle from the bottom. Once it has
// landed, FT pulses for one cycle.
module gestor_jugada #(
  parameter int COLS = 7,
  parameter int ROWS = 6
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              enable,
  input  logic                              btnIzq,
  input  logic                              btnDer,
  input  logic                              btnEnt,
  input  logic                              jugador,
  output logic                              FT,
  output logic [COLS-1:0]                   posicion,
  output logic [ROWS-1:0][COLS-1:0]         tablero,
  output logic [ROWS-1:0][COLS-1:0]         fichas,
  output logic [$clog2(ROWS)-1:0]           fila_jugada,
  output logic [$clog2(COLS)-1:0]           col_jugada,
  output logic                              tablero_lleno,
  output logic [1:0]                        o_estado
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam logic [CW:0] LP_COLS = (CW+1)'(COLS);

  typedef enum logic [1:0] {
    S_SELECT = 2'd0,
    S_DROP   = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  state_t                    r_state;
  state_t                    w_state_next;
  logic [CW-1:0]             r_col;
  logic [CW-1:0]             r_drop_col;
  logic [RW-1:0]             r_row;
  logic                      r_player;
  logic [ROWS-1:0][COLS-1:0] r_tablero;
  logic [ROWS-1:0][COLS-1:0] r_fichas;
  logic [RW-1:0]             r_fila;
  logic [CW-1:0]             r_colj;
  logic                      r_izq_q;
  logic                      r_der_q;
  logic                      r_ent_q;

  logic                      w_ev_izq;
  logic                      w_ev_der;
  logic                      w_ev_ent;
  logic [COLS-1:0]           w_full;
  logic [CW-1:0]             w_right;
  logic                      w_right_ok;
  logic [CW-1:0]             w_left;
  logic                      w_left_ok;
  logic [CW:0]               w_sr;
  logic [CW:0]               w_sl;
  logic                      w_start;
  logic                      w_move_r;
  logic                      w_move_l;
  logic                      w_place;

  // Button protocol: an event is a single-cycle 0->1 transition of a level
  // input. Events are consumed only in SELECT with enable high. Events that
  // arrive in any other cycle are dropped and never queued.
  assign w_ev_izq = btnIzq & ~r_izq_q;
  assign w_ev_der = btnDer & ~r_der_q;
  assign w_ev_ent = btnEnt & ~r_ent_q;

  // A column is full exactly when its top cell is occupied.
  assign w_full = r_tablero[ROWS-1];

  // Nearest non-full column in each direction, with wrap. The loop runs from
  // the farthest candidate to the nearest, so the nearest match wins.
  always_comb begin
    w_right    = r_col;
    w_right_ok = 1'b0;
    w_left     = r_col;
    w_left_ok  = 1'b0;
    w_sr       = '0;
    w_sl       = '0;
    for (int k = COLS - 1; k >= 1; k--) begin
      w_sr = {1'b0, r_col} + (CW+1)'(k);
      if (w_sr >= LP_COLS) w_sr = w_sr - LP_COLS;
      if (!w_full[w_sr[CW-1:0]]) begin
        w_right    = w_sr[CW-1:0];
        w_right_ok = 1'b1;
      end
      w_sl = {1'b0, r_col} + LP_COLS - (CW+1)'(k);
      if (w_sl >= LP_COLS) w_sl = w_sl - LP_COLS;
      if (!w_full[w_sl[CW-1:0]]) begin
        w_left    = w_sl[CW-1:0];
        w_left_ok = 1'b1;
      end
    end
  end

  // Next-state and control decode. Drop wins over moves, and opposing moves cancel.
  always_comb begin
    w_state_next = r_state;
    w_start      = 1'b0;
    w_move_r     = 1'b0;
    w_move_l     = 1'b0;
    w_place      = 1'b0;
    case (r_state)
      S_SELECT: begin
        if (enable) begin
          if (w_ev_ent) begin
            if (!w_full[r_col]) begin
              w_start      = 1'b1;
              w_state_next = S_DROP;
            end
          end else if (w_ev_der ^ w_ev_izq) begin
            w_move_r = w_ev_der;
            w_move_l = w_ev_izq;
          end
        end
      end
      S_DROP: begin
        if (!r_tablero[r_row][r_drop_col]) begin
          w_place      = 1'b1;
          w_state_next = S_DONE;
        end
      end
      S_DONE:  w_state_next = S_SELECT;
      default: w_state_next = S_SELECT;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_SELECT;
    else       r_state <= w_state_next;
  end

  // Datapath: edge samples, cursor, drop scan, and board contents.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_izq_q    <= 1'b0;
      r_der_q    <= 1'b0;
      r_ent_q    <= 1'b0;
      r_col      <= '0;
      r_drop_col <= '0;
      r_row      <= '0;
      r_player   <= 1'b0;
      r_tablero  <= '0;
      r_fichas   <= '0;
      r_fila     <= '0;
      r_colj     <= '0;
    end else begin
      r_izq_q <= btnIzq;
      r_der_q <= btnDer;
      r_ent_q <= btnEnt;
      if (w_move_r && w_right_ok) r_col <= w_right;
      if (w_move_l && w_left_ok)  r_col <= w_left;
      if (w_start) begin
        r_drop_col <= r_col;
        r_player   <= jugador;
        r_row      <= '0;
      end
      if (r_state == S_DROP && !w_place) r_row <= r_row + 1'b1;
      if (w_place) begin
        r_tablero[r_row][r_drop_col] <= 1'b1;
        r_fichas[r_row][r_drop_col]  <= r_player;
        r_fila                       <= r_row;
        r_colj                       <= r_drop_col;
      end
      // The board has just been updated. Move the cursor off a column that is now full.
      if (r_state == S_DONE && w_full[r_col] && w_right_ok) r_col <= w_right;
    end
  end

  assign FT            = (r_state == S_DONE);
  assign posicion      = {{(COLS-1){1'b0}}, 1'b1} << r_col;
  assign tablero       = r_tablero;
  assign fichas        = r_fichas;
  assign fila_jugada   = r_fila;
  assign col_jugada    = r_colj;
  assign tablero_lleno = &w_full;
  assign o_estado      = r_state;

endmodule

// File: tb/tb_gestor_jugada.sv
// Directed testbench for gestor_jugada on a 7x6 board.
module tb_gestor_jugada;

  localparam int COLS = 7;
  localparam int ROWS = 6;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      enable;
  logic                      btnIzq;
  logic                      btnDer;
  logic                      btnEnt;
  logic                      jugador;
  logic                      FT;
  logic [COLS-1:0]           posicion;
  logic [ROWS-1:0][COLS-1:0] tablero;
  logic [ROWS-1:0][COLS-1:0] fichas;
  logic [2:0]                fila_jugada;
  logic [2:0]                col_jugada;
  logic                      tablero_lleno;
  logic [1:0]                o_estado;

  int n_vec = 0;
  int n_err = 0;

  gestor_jugada #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk(clk), .reset(reset), .enable(enable),
    .btnIzq(btnIzq), .btnDer(btnDer), .btnEnt(btnEnt), .jugador(jugador),
    .FT(FT), .posicion(posicion), .tablero(tablero), .fichas(fichas),
    .fila_jugada(fila_jugada), .col_jugada(col_jugada),
    .tablero_lleno(tablero_lleno), .o_estado(o_estado)
  );

  // Clock generation.
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle pulse on the selected buttons, then one idle cycle so the edge detector re-arms.
  task automatic pulse(input logic izq, input logic der, input logic ent);
    btnIzq = izq; btnDer = der; btnEnt = ent;
    tick();
    btnIzq = 1'b0; btnDer = 1'b0; btnEnt = 1'b0;
    tick();
  endtask

  // Count the cycles until FT is seen. Returns 99 if FT never rises within 20 cycles.
  task automatic wait_ft(output int lat);
    logic seen;
    seen = 1'b0;
    lat  = 99;
    for (int i = 1; i <= 20 && !seen; i++) begin
      tick();
      if (FT === 1'b1) begin
        seen = 1'b1;
        lat  = i;
      end
    end
  endtask

  // Drop a full piece: pulse btnEnt, wait for FT, then let DONE finish.
  task automatic do_drop(input logic pl, output int lat);
    jugador = pl;
    btnEnt  = 1'b1;
    tick();
    btnEnt  = 1'b0;
    wait_ft(lat);
    tick();
  endtask

  task automatic test_reset;
    reset = 1'b1; enable = 1'b0; btnIzq = 1'b0; btnDer = 1'b0; btnEnt = 1'b0; jugador = 1'b0;
    tick(); tick();
    reset = 1'b0;
    n_vec++; if (posicion !== 7'b0000001) begin n_err++; $display("FAIL reset_posicion: got %b want %b", posicion, 7'b0000001); end
    n_vec++; if (tablero !== '0) begin n_err++; $display("FAIL reset_tablero: got %h want 0", tablero); end
    n_vec++; if (fichas !== '0) begin n_err++; $display("FAIL reset_fichas: got %h want 0", fichas); end
    n_vec++; if ({FT, tablero_lleno} !== 2'b00) begin n_err++; $display("FAIL reset_flags: FT,lleno got %b want 00", {FT, tablero_lleno}); end
    n_vec++; if ({fila_jugada, col_jugada} !== 6'd0) begin n_err++; $display("FAIL reset_coords: got %0d,%0d want 0,0", fila_jugada, col_jugada); end
    n_vec++; if (o_estado !== 2'd0) begin n_err++; $display("FAIL reset_state: got %0d want 0", o_estado); end
  endtask

  task automatic test_move;
    enable = 1'b1;
    pulse(1'b1, 1'b0, 1'b0);
    n_vec++; if (posicion !== 7'b1000000) begin n_err++; $display("FAIL move_left_wrap: got %b want %b", posicion, 7'b1000000); end
    pulse(1'b0, 1'b1, 1'b0);
    n_vec++; if (posicion !== 7'b0000001) begin n_err++; $display("FAIL move_right_wrap: got %b want %b", posicion, 7'b0000001); end
    pulse(1'b0, 1'b1, 1'b0);
    n_vec++; if (posicion !== 7'b0000010) begin n_err++; $display("FAIL move_right: got %b want %b", posicion, 7'b0000010); end
  endtask

  task automatic test_drop;
    int lat;
    logic [ROWS-1:0][COLS-1:0] exp_t;
    jugador = 1'b1; btnEnt = 1'b1;
    tick();
    btnEnt = 1'b0; jugador = 1'b0;
    n_vec++; if (o_estado !== 2'd1) begin n_err++; $display("FAIL drop_enter_state: got %0d want 1", o_estado); end
    wait_ft(lat);
    n_vec++; if (lat !== 1) begin n_err++; $display("FAIL drop_row0_latency: got %0d want 1", lat); end
    n_vec++; if ({fila_jugada, col_jugada} !== {3'd0, 3'd1}) begin n_err++; $display("FAIL drop_row0_coords: got %0d,%0d want 0,1", fila_jugada, col_jugada); end
    n_vec++; if ({tablero[0][1], fichas[0][1]} !== 2'b11) begin n_err++; $display("FAIL drop_row0_cell: got %b want 11", {tablero[0][1], fichas[0][1]}); end
    tick();
    n_vec++; if (FT !== 1'b0) begin n_err++; $display("FAIL ft_one_cycle: got %b want 0", FT); end
    // Second piece. enable drops and jugador flips mid-drop, and neither may affect it.
    jugador = 1'b0; btnEnt = 1'b1;
    tick();
    btnEnt = 1'b0; enable = 1'b0; jugador = 1'b1;
    wait_ft(lat);
    n_vec++; if (lat !== 2) begin n_err++; $display("FAIL drop_row1_latency: got %0d want 2", lat); end
    n_vec++; if ({fila_jugada, col_jugada} !== {3'd1, 3'd1}) begin n_err++; $display("FAIL drop_row1_coords: got %0d,%0d want 1,1", fila_jugada, col_jugada); end
    n_vec++; if (fichas[1][1] !== 1'b0) begin n_err++; $display("FAIL drop_row1_owner: got %b want 0", fichas[1][1]); end
    exp_t = '0; exp_t[0][1] = 1'b1; exp_t[1][1] = 1'b1;
    n_vec++; if (tablero !== exp_t) begin n_err++; $display("FAIL drop_board: got %h want %h", tablero, exp_t); end
    enable = 1'b1;
    tick();
  endtask

  task automatic test_fill_column;
    int lat;
    logic [ROWS-1:0] c3;
    pulse(1'b0, 1'b1, 1'b0);
    pulse(1'b0, 1'b1, 1'b0);
    n_vec++; if (posicion !== 7'b0001000) begin n_err++; $display("FAIL move_to_col3: got %b want %b", posicion, 7'b0001000); end
    // btnEnt held for 5 cycles must give a single piece.
    jugador = 1'b0; btnEnt = 1'b1;
    repeat (5) tick();
    btnEnt = 1'b0;
    tick();
    n_vec++; if ({tablero[1][3], tablero[0][3]} !== 2'b01) begin n_err++; $display("FAIL held_ent_single: got %b want 01", {tablero[1][3], tablero[0][3]}); end
    for (int r = 1; r < ROWS; r++) begin
      do_drop(r[0], lat);
      n_vec++; if (lat !== r + 1) begin n_err++; $display("FAIL col3_latency_row%0d: got %0d want %0d", r, lat, r + 1); end
    end
    for (int r = 0; r < ROWS; r++) c3[r] = tablero[r][3];
    n_vec++; if (c3 !== 6'b111111) begin n_err++; $display("FAIL col3_full: got %b want 111111", c3); end
    n_vec++; if (posicion !== 7'b0010000) begin n_err++; $display("FAIL auto_move: got %b want %b", posicion, 7'b0010000); end
    pulse(1'b1, 1'b0, 1'b0);
    n_vec++; if (posicion !== 7'b0000100) begin n_err++; $display("FAIL skip_full_left: got %b want %b", posicion, 7'b0000100); end
    pulse(1'b0, 1'b1, 1'b0);
    n_vec++; if (posicion !== 7'b0010000) begin n_err++; $display("FAIL skip_full_right: got %b want %b", posicion, 7'b0010000); end
  endtask

  task automatic test_simultaneous;
    int lat;
    pulse(1'b1, 1'b1, 1'b0);
    n_vec++; if (posicion !== 7'b0010000) begin n_err++; $display("FAIL izq_der_cancel: got %b want %b", posicion, 7'b0010000); end
    jugador = 1'b1; btnEnt = 1'b1; btnDer = 1'b1;
    tick();
    btnEnt = 1'b0; btnDer = 1'b0;
    wait_ft(lat);
    n_vec++; if ({lat == 1, col_jugada} !== {1'b1, 3'd4}) begin n_err++; $display("FAIL ent_beats_move: lat %0d col %0d want lat 1 col 4", lat, col_jugada); end
    n_vec++; if (fichas[0][4] !== 1'b1) begin n_err++; $display("FAIL ent_move_owner: got %b want 1", fichas[0][4]); end
    tick();
    n_vec++; if (posicion !== 7'b0010000) begin n_err++; $display("FAIL ent_move_cursor: got %b want %b", posicion, 7'b0010000); end
  endtask

  task automatic test_reset_mid_drop;
    int lat;
    logic ft_seen;
    do_drop(1'b0, lat);
    do_drop(1'b1, lat);
    ft_seen = 1'b0;
    jugador = 1'b0; btnEnt = 1'b1;
    tick();
    btnEnt = 1'b0;
    tick();
    if (FT === 1'b1) ft_seen = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    if (FT === 1'b1) ft_seen = 1'b1;
    repeat (6) begin
      tick();
      if (FT === 1'b1) ft_seen = 1'b1;
    end
    n_vec++; if (ft_seen !== 1'b0) begin n_err++; $display("FAIL reset_drop_ft: got %b want 0", ft_seen); end
    n_vec++; if ({tablero, fichas} !== '0) begin n_err++; $display("FAIL reset_drop_board: got %h / %h want 0", tablero, fichas); end
    n_vec++; if (posicion !== 7'b0000001) begin n_err++; $display("FAIL reset_drop_cursor: got %b want %b", posicion, 7'b0000001); end
    enable = 1'b0;
    pulse(1'b0, 1'b0, 1'b1);
    repeat (4) tick();
    pulse(1'b1, 1'b0, 1'b0);
    n_vec++; if (tablero !== '0) begin n_err++; $display("FAIL disabled_ent: got %h want 0", tablero); end
    n_vec++; if (posicion !== 7'b0000001) begin n_err++; $display("FAIL disabled_move: got %b want %b", posicion, 7'b0000001); end
    enable = 1'b1;
  endtask

  task automatic test_board_full;
    int lat;
    logic pl;
    logic [ROWS-1:0][COLS-1:0] exp_f;
    exp_f = '0;
    for (int c = 0; c < COLS; c++) begin
      for (int r = 0; r < ROWS; r++) begin
        pl = ((r + c) % 2) == 1;
        if (c == COLS - 1 && r == ROWS - 1) begin
          n_vec++; if (tablero_lleno !== 1'b0) begin n_err++; $display("FAIL lleno_early: got %b want 0", tablero_lleno); end
        end
        do_drop(pl, lat);
        n_vec++; if (lat !== r + 1) begin n_err++; $display("FAIL fill_latency_r%0d_c%0d: got %0d want %0d", r, c, lat, r + 1); end
        exp_f[r][c] = pl;
      end
    end
    for (int pass = 0; pass < 2; pass++) begin
      n_vec++; if (tablero !== {(ROWS*COLS){1'b1}}) begin n_err++; $display("FAIL full_board_p%0d: got %h", pass, tablero); end
      n_vec++; if (fichas !== exp_f) begin n_err++; $display("FAIL full_fichas_p%0d: got %h want %h", pass, fichas, exp_f); end
      n_vec++; if ({tablero_lleno, FT} !== 2'b10) begin n_err++; $display("FAIL full_flags_p%0d: lleno,FT got %b want 10", pass, {tablero_lleno, FT}); end
      n_vec++; if (posicion !== 7'b1000000) begin n_err++; $display("FAIL full_cursor_p%0d: got %b want %b", pass, posicion, 7'b1000000); end
      n_vec++; if ({fila_jugada, col_jugada} !== {3'd5, 3'd6}) begin n_err++; $display("FAIL full_coords_p%0d: got %0d,%0d want 5,6", pass, fila_jugada, col_jugada); end
      if (pass == 0) begin
        pulse(1'b0, 1'b0, 1'b1);
        repeat (3) tick();
        pulse(1'b1, 1'b0, 1'b0);
        pulse(1'b0, 1'b1, 1'b0);
      end
    end
  endtask

  // Test sequence.
  initial begin
    test_reset();
    test_move();
    test_drop();
    test_fill_column();
    test_simultaneous();
    test_reset_mid_drop();
    test_board_full();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
